// File: rtl/dcmi_pkg.sv
// Shared types and constants for the DCMI capture sequencer.
//   dcmi_state_e   : capture FSM states
//   FCRC_*         : frame-rate control encodings
//   frame_selected : decides whether the frame that is starting gets captured
package dcmi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2,
        SKIP     = 2'd3
    } dcmi_state_e;

    localparam logic [1:0] FCRC_ALL     = 2'b00;
    localparam logic [1:0] FCRC_HALF    = 2'b01;
    localparam logic [1:0] FCRC_QUARTER = 2'b10;

    localparam int unsigned FRAME_CNT_W = 2;

    // The counter value passed in is the one held before this frame's increment.
    function automatic logic frame_selected(input logic [1:0]             fcrc,
                                            input logic [FRAME_CNT_W-1:0] cnt);
        logic sel;
        case (fcrc)
            FCRC_ALL:     sel = 1'b1;
            FCRC_HALF:    sel = ~cnt[0];
            FCRC_QUARTER: sel = (cnt == '0);
            default:      sel = 1'b1;   // 2'b11 behaves as "all frames"
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dcmi_sync_edge.sv
// Sync-signal normaliser and blanking edge detector.
//   clk, rstn       : clock, async active-low reset
//   enable          : block enable; edges are reported only when it was also high last cycle
//   sync_in         : synchronised VSYNC or HSYNC
//   blank_pol       : sync level that means blanking
//   blank_c         : current blanking level (combinational)
//   enter_blank_c   : active -> blanking transition this cycle (combinational)
//   leave_blank_c   : blanking -> active transition this cycle (combinational)
module dcmi_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic sync_in,
    input  logic blank_pol,
    output logic blank_c,
    output logic enter_blank_c,
    output logic leave_blank_c
);

    logic blank_d;
    logic enable_d;

    assign blank_c = (sync_in == blank_pol);

    // History runs every cycle, even while disabled, so enabling mid-frame sees no edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blank_d  <= 1'b0;
            enable_d <= 1'b0;
        end else begin
            blank_d  <= blank_c;
            enable_d <= enable;
        end
    end

    assign enter_blank_c = enable & enable_d & ~blank_d &  blank_c;
    assign leave_blank_c = enable & enable_d &  blank_d & ~blank_c;

endmodule

// File: rtl/dcmi_capture_ctrl.sv
// DCMI capture sequencer: tracks VSYNC/HSYNC framing, runs continuous or
// snapshot capture with frame-rate decimation, gates the pixel path and
// produces the line / vsync / frame-end event pulses.
//   clk, rstn            : clock, async active-low reset
//   dcmi_enable          : 0 forces IDLE and clears counters
//   dcmi_capture         : capture request
//   dcmi_cm              : 0 continuous, 1 snapshot
//   dcmi_fcrc            : frame-rate control
//   dcmi_vspol/hspol     : sync levels meaning blanking
//   vsync, hsync         : synchronised sync inputs
//   capture_clr          : pulse clearing the capture request after a snapshot
//   frame_active         : FSM is in ACTIVE
//   line_valid           : pixel qualifier (pixels are delayed one cycle downstream)
//   line_cnt             : lines completed in the current captured frame
//   line_irq_pulse       : end of a captured line
//   vsync_irq_pulse      : start of vertical blanking while not IDLE
//   frame_end_irq_pulse  : end of a captured frame
module dcmi_capture_ctrl
    import dcmi_pkg::*;
#(
    parameter int unsigned LINE_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dcmi_enable,
    input  logic              dcmi_capture,
    input  logic              dcmi_cm,
    input  logic [1:0]        dcmi_fcrc,
    input  logic              dcmi_vspol,
    input  logic              dcmi_hspol,
    input  logic              vsync,
    input  logic              hsync,
    output logic              capture_clr,
    output logic              frame_active,
    output logic              line_valid,
    output logic [LINE_W-1:0] line_cnt,
    output logic              line_irq_pulse,
    output logic              vsync_irq_pulse,
    output logic              frame_end_irq_pulse
);

    dcmi_state_e            state_q;
    dcmi_state_e            state_nxt;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_nxt;
    logic [LINE_W-1:0]      line_cnt_nxt;
    logic                   capture_clr_nxt;
    logic                   frame_active_nxt;
    logic                   line_valid_nxt;
    logic                   line_irq_nxt;
    logic                   vsync_irq_nxt;
    logic                   frame_end_irq_nxt;

    logic vblank_c;
    logic hblank_c;
    logic sof_c;
    logic eof_c;
    logic eol_c;
    logic line_start_unused;

    // Vertical framing: leaving blanking starts a frame, entering it ends one.
    dcmi_sync_edge u_vsync_edge (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (dcmi_enable),
        .sync_in       (vsync),
        .blank_pol     (dcmi_vspol),
        .blank_c       (vblank_c),
        .enter_blank_c (eof_c),
        .leave_blank_c (sof_c)
    );

    // Horizontal framing: entering blanking ends a line.
    dcmi_sync_edge u_hsync_edge (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (dcmi_enable),
        .sync_in       (hsync),
        .blank_pol     (dcmi_hspol),
        .blank_c       (hblank_c),
        .enter_blank_c (eol_c),
        .leave_blank_c (line_start_unused)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        if (!dcmi_enable) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dcmi_capture) state_nxt = WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (!dcmi_capture) begin
                        state_nxt = IDLE;
                    end else if (sof_c) begin
                        state_nxt = frame_selected(dcmi_fcrc, frame_cnt_q) ? ACTIVE : SKIP;
                    end
                end
                ACTIVE: begin
                    // A dropped request only takes effect once the frame completes.
                    if (eof_c) begin
                        state_nxt = (dcmi_cm || !dcmi_capture) ? IDLE : WAIT_SOF;
                    end
                end
                SKIP: begin
                    if (eof_c) state_nxt = dcmi_capture ? WAIT_SOF : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output / counter next values; everything here is registered below.
    always_comb begin
        frame_cnt_nxt     = frame_cnt_q;
        line_cnt_nxt      = line_cnt;
        capture_clr_nxt   = 1'b0;
        line_irq_nxt      = 1'b0;
        vsync_irq_nxt     = 1'b0;
        frame_end_irq_nxt = 1'b0;

        if (!dcmi_enable) begin
            frame_cnt_nxt = '0;
            line_cnt_nxt  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dcmi_capture) frame_cnt_nxt = '0;
                end
                WAIT_SOF: begin
                    vsync_irq_nxt = eof_c;
                    if (dcmi_capture && sof_c) begin
                        frame_cnt_nxt = frame_cnt_q + FRAME_CNT_W'(1);
                        line_cnt_nxt  = '0;
                    end
                end
                ACTIVE: begin
                    vsync_irq_nxt = eof_c;
                    if (eol_c) begin
                        line_irq_nxt = 1'b1;
                        if (line_cnt != '1) line_cnt_nxt = line_cnt + LINE_W'(1);
                    end
                    if (eof_c) begin
                        frame_end_irq_nxt = 1'b1;
                        capture_clr_nxt   = dcmi_cm;
                    end
                end
                SKIP: begin
                    vsync_irq_nxt = eof_c;
                end
                default: ;
            endcase
        end

        // Qualify with the state being entered so the first pixel after sof is valid.
        frame_active_nxt = (state_nxt == ACTIVE);
        line_valid_nxt   = (state_nxt == ACTIVE) & ~vblank_c & ~hblank_c;
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q         <= '0;
            line_cnt            <= '0;
            capture_clr         <= 1'b0;
            frame_active        <= 1'b0;
            line_valid          <= 1'b0;
            line_irq_pulse      <= 1'b0;
            vsync_irq_pulse     <= 1'b0;
            frame_end_irq_pulse <= 1'b0;
        end else begin
            frame_cnt_q         <= frame_cnt_nxt;
            line_cnt            <= line_cnt_nxt;
            capture_clr         <= capture_clr_nxt;
            frame_active        <= frame_active_nxt;
            line_valid          <= line_valid_nxt;
            line_irq_pulse      <= line_irq_nxt;
            vsync_irq_pulse     <= vsync_irq_nxt;
            frame_end_irq_pulse <= frame_end_irq_nxt;
        end
    end

endmodule

// File: tb/tb_dcmi_capture_ctrl.sv
// Directed bench for dcmi_capture_ctrl: drives synthetic frames of PIX pixels
// per line and compares event counts and output levels with hand-derived values.
module tb_dcmi_capture_ctrl;

    localparam int unsigned LINE_W = 14;
    localparam int          PIX    = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic              dcmi_enable;
    logic              dcmi_capture;
    logic              dcmi_cm;
    logic [1:0]        dcmi_fcrc;
    logic              dcmi_vspol;
    logic              dcmi_hspol;
    logic              vsync;
    logic              hsync;
    logic              capture_clr;
    logic              frame_active;
    logic              line_valid;
    logic [LINE_W-1:0] line_cnt;
    logic              line_irq_pulse;
    logic              vsync_irq_pulse;
    logic              frame_end_irq_pulse;

    int checks = 0;
    int errors = 0;
    int n_line, n_vs, n_fe, n_clr, n_clr_fe, n_lv, n_fe_lc;
    int exp_lc = 4;

    always #5 clk = ~clk;

    dcmi_capture_ctrl #(.LINE_W(LINE_W)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .dcmi_enable         (dcmi_enable),
        .dcmi_capture        (dcmi_capture),
        .dcmi_cm             (dcmi_cm),
        .dcmi_fcrc           (dcmi_fcrc),
        .dcmi_vspol          (dcmi_vspol),
        .dcmi_hspol          (dcmi_hspol),
        .vsync               (vsync),
        .hsync               (hsync),
        .capture_clr         (capture_clr),
        .frame_active        (frame_active),
        .line_valid          (line_valid),
        .line_cnt            (line_cnt),
        .line_irq_pulse      (line_irq_pulse),
        .vsync_irq_pulse     (vsync_irq_pulse),
        .frame_end_irq_pulse (frame_end_irq_pulse)
    );

    task automatic clear_counts();
        n_line = 0; n_vs = 0; n_fe = 0; n_clr = 0; n_clr_fe = 0; n_lv = 0; n_fe_lc = 0;
    endtask

    // One clock: apply blanking levels, sample #1 after the edge, tally events.
    task automatic cyc(input logic vb, input logic hb);
        vsync = vb ? dcmi_vspol : ~dcmi_vspol;
        hsync = hb ? dcmi_hspol : ~dcmi_hspol;
        @(posedge clk);
        #1;
        if (line_irq_pulse)  n_line++;
        if (vsync_irq_pulse) n_vs++;
        if (frame_end_irq_pulse) n_fe++;
        if (capture_clr) n_clr++;
        if (capture_clr && frame_end_irq_pulse) n_clr_fe++;
        if (line_valid) n_lv++;
        if (frame_end_irq_pulse && line_cnt == LINE_W'(exp_lc)) n_fe_lc++;
        if (capture_clr) dcmi_capture = 1'b0;   // register-side clear of CR.CAPTURE
    endtask

    // nlines active lines, then vertical blanking; capture drops in drop_line.
    task automatic frame(input int nlines, input int drop_line);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < PIX; p++) begin
                cyc(1'b0, 1'b0);
                if (l == drop_line && p == 0) dcmi_capture = 1'b0;
            end
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b1);
        end
        repeat (3) cyc(1'b1, 1'b1);
    endtask

    task automatic prep(input logic cm, input logic [1:0] fcrc, input logic vp, input logic hp);
        dcmi_enable = 1'b0; dcmi_capture = 1'b0;
        dcmi_cm = cm; dcmi_fcrc = fcrc; dcmi_vspol = vp; dcmi_hspol = hp;
        repeat (3) cyc(1'b1, 1'b1);
        dcmi_enable = 1'b1; dcmi_capture = 1'b1;
        repeat (3) cyc(1'b1, 1'b1);
        clear_counts();
    endtask

    task automatic test_reset();
        rstn = 1'b0; dcmi_enable = 1'b0; dcmi_capture = 1'b0; dcmi_cm = 1'b0;
        dcmi_fcrc = 2'b00; dcmi_vspol = 1'b1; dcmi_hspol = 1'b1; vsync = 1'b1; hsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (capture_clr !== 1'b0) begin errors++; $display("FAIL rst_capture_clr: got %b expected 0", capture_clr); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL rst_frame_active: got %b expected 0", frame_active); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL rst_line_valid: got %b expected 0", line_valid); end
        checks++; if (line_cnt !== '0) begin errors++; $display("FAIL rst_line_cnt: got %0d expected 0", line_cnt); end
        checks++; if ({line_irq_pulse, vsync_irq_pulse, frame_end_irq_pulse} !== 3'b000) begin
            errors++; $display("FAIL rst_pulses: got %b expected 000", {line_irq_pulse, vsync_irq_pulse, frame_end_irq_pulse}); end
        rstn = 1'b1;
    endtask

    task automatic test_continuous();
        prep(1'b0, 2'b00, 1'b1, 1'b1);
        exp_lc = 4;
        repeat (3) frame(4, -1);
        checks++; if (n_fe !== 3) begin errors++; $display("FAIL cont_frame_end: got %0d expected 3", n_fe); end
        checks++; if (n_line !== 12) begin errors++; $display("FAIL cont_line_irq: got %0d expected 12", n_line); end
        checks++; if (n_vs !== 3) begin errors++; $display("FAIL cont_vsync_irq: got %0d expected 3", n_vs); end
        checks++; if (n_fe_lc !== 3) begin errors++; $display("FAIL cont_line_cnt_at_end: got %0d frames with 4 lines expected 3", n_fe_lc); end
        checks++; if (n_clr !== 0) begin errors++; $display("FAIL cont_capture_clr: got %0d expected 0", n_clr); end
        checks++; if (n_lv !== 36) begin errors++; $display("FAIL cont_line_valid: got %0d cycles expected 36", n_lv); end
    endtask

    task automatic test_snapshot();
        prep(1'b1, 2'b00, 1'b1, 1'b1);
        exp_lc = 4;
        frame(4, -1);
        checks++; if (n_fe !== 1) begin errors++; $display("FAIL snap_frame_end: got %0d expected 1", n_fe); end
        checks++; if (n_line !== 4) begin errors++; $display("FAIL snap_line_irq: got %0d expected 4", n_line); end
        checks++; if (n_clr_fe !== 1 || n_clr !== 1) begin errors++; $display("FAIL snap_clr_with_fe: got %0d/%0d expected 1/1", n_clr_fe, n_clr); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL snap_idle: got frame_active %b expected 0", frame_active); end
        clear_counts();
        frame(4, -1);
        checks++; if (n_fe + n_line + n_vs + n_clr !== 0) begin errors++; $display("FAIL snap_second_frame_pulses: got %0d expected 0", n_fe + n_line + n_vs + n_clr); end
        checks++; if (n_lv !== 0) begin errors++; $display("FAIL snap_second_frame_lv: got %0d expected 0", n_lv); end
    endtask

    task automatic test_fcrc_quarter();
        prep(1'b0, 2'b10, 1'b0, 1'b0);
        exp_lc = 4;
        repeat (8) frame(4, -1);
        checks++; if (n_fe !== 2) begin errors++; $display("FAIL quarter_frame_end: got %0d expected 2", n_fe); end
        checks++; if (n_line !== 8) begin errors++; $display("FAIL quarter_line_irq: got %0d expected 8", n_line); end
        checks++; if (n_vs !== 8) begin errors++; $display("FAIL quarter_vsync_irq: got %0d expected 8", n_vs); end
        checks++; if (n_lv !== 24) begin errors++; $display("FAIL quarter_line_valid: got %0d cycles expected 24", n_lv); end
    endtask

    task automatic test_mid_frame_enable();
        dcmi_enable = 1'b0; dcmi_capture = 1'b0; dcmi_cm = 1'b0; dcmi_fcrc = 2'b00;
        dcmi_vspol = 1'b1; dcmi_hspol = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);
        clear_counts();
        dcmi_enable = 1'b1; dcmi_capture = 1'b1;
        frame(2, -1);
        checks++; if (n_line !== 0) begin errors++; $display("FAIL mid_partial_line_irq: got %0d expected 0", n_line); end
        checks++; if (n_fe !== 0) begin errors++; $display("FAIL mid_partial_frame_end: got %0d expected 0", n_fe); end
        checks++; if (n_vs !== 1) begin errors++; $display("FAIL mid_partial_vsync_irq: got %0d expected 1", n_vs); end
        checks++; if (n_lv !== 0) begin errors++; $display("FAIL mid_partial_line_valid: got %0d expected 0", n_lv); end
        clear_counts();
        exp_lc = 4;
        frame(4, -1);
        checks++; if (n_fe !== 1 || n_line !== 4) begin errors++; $display("FAIL mid_next_frame: got fe %0d lines %0d expected 1 4", n_fe, n_line); end
        checks++; if (n_fe_lc !== 1) begin errors++; $display("FAIL mid_next_line_cnt: got %0d expected 1", n_fe_lc); end
    endtask

    task automatic test_capture_drop();
        prep(1'b0, 2'b00, 1'b1, 1'b1);
        exp_lc = 4;
        frame(4, 1);
        checks++; if (n_fe !== 1) begin errors++; $display("FAIL drop_frame_end: got %0d expected 1", n_fe); end
        checks++; if (n_line !== 4) begin errors++; $display("FAIL drop_line_irq: got %0d expected 4", n_line); end
        checks++; if (n_fe_lc !== 1) begin errors++; $display("FAIL drop_line_cnt: got %0d expected 1", n_fe_lc); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL drop_idle: got frame_active %b expected 0", frame_active); end
        clear_counts();
        frame(4, -1);
        checks++; if (n_line + n_fe + n_vs !== 0) begin errors++; $display("FAIL drop_next_pulses: got %0d expected 0", n_line + n_fe + n_vs); end
        checks++; if (n_lv !== 0) begin errors++; $display("FAIL drop_next_line_valid: got %0d expected 0", n_lv); end
    endtask

    task automatic test_simultaneous();
        prep(1'b0, 2'b00, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        checks++; if ({line_irq_pulse, frame_end_irq_pulse, vsync_irq_pulse} !== 3'b111) begin
            errors++; $display("FAIL sim_pulses: got %b expected 111", {line_irq_pulse, frame_end_irq_pulse, vsync_irq_pulse}); end
        checks++; if (line_cnt !== LINE_W'(2)) begin errors++; $display("FAIL sim_line_cnt: got %0d expected 2", line_cnt); end
        repeat (2) cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);
        checks++; if ({line_valid, frame_active} !== 2'b11 || line_cnt !== LINE_W'(1)) begin
            errors++; $display("FAIL sim_active_line: got lv/fa %b cnt %0d expected 11 cnt 1", {line_valid, frame_active}, line_cnt); end
        dcmi_enable = 1'b0;
        cyc(1'b0, 1'b0);
        checks++; if ({line_valid, frame_active} !== 2'b00) begin errors++; $display("FAIL dis_idle: got lv/fa %b expected 00", {line_valid, frame_active}); end
        checks++; if (line_cnt !== '0) begin errors++; $display("FAIL dis_line_cnt: got %0d expected 0", line_cnt); end
    endtask

    task automatic test_async_reset();
        prep(1'b0, 2'b00, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL ar_before: got frame_active %b expected 1", frame_active); end
        #2 rstn = 1'b0;
        #1;
        checks++; if ({frame_active, line_valid} !== 2'b00) begin errors++; $display("FAIL ar_immediate: got fa/lv %b expected 00", {frame_active, line_valid}); end
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b1);
        clear_counts();
        exp_lc = 4;
        frame(4, -1);
        checks++; if (n_fe !== 1 || n_line !== 4) begin errors++; $display("FAIL ar_restart: got fe %0d lines %0d expected 1 4", n_fe, n_line); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_continuous();
        test_snapshot();
        test_fcrc_quarter();
        test_mid_frame_enable();
        test_capture_drop();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcmi_capture_ctrl.md
Name: dcmi_capture_ctrl

Overview:
- Capture sequencer for the DCMI receive path.
- Tracks VSYNC/HSYNC framing and runs continuous or snapshot capture per the CR fields (CAPTURE, CM, FCRC, polarities).
- Gates the pixel datapath with line_valid.
- Generates the line/vsync/frame-end event pulses consumed by the interrupt status block.
- Inputs are already synchronous to clk; CDC is done upstream.

Parameters:
- LINE_W, 14, width of the captured-line counter.

Ports:
- clk  input  1  system clock
- rstn  input  1  async active-low reset
- dcmi_enable  input  1  CR.ENABLE; 0 forces idle
- dcmi_capture  input  1  CR.CAPTURE request
- dcmi_cm  input  1  0 = continuous, 1 = snapshot
- dcmi_fcrc  input  2  frame-rate control: 00 all frames, 01 every other frame, 10 one in four, 11 treated as 00
- dcmi_vspol  input  1  VSYNC level that means vertical blanking
- dcmi_hspol  input  1  HSYNC level that means horizontal blanking
- vsync  input  1  synchronized VSYNC
- hsync  input  1  synchronized HSYNC
- capture_clr  output  1  one-cycle pulse that clears CR.CAPTURE after a snapshot frame
- frame_active  output  1  high while the FSM is in ACTIVE
- line_valid  output  1  pixel-qualify for the datapath, registered
- line_cnt  output  LINE_W  lines completed in the current captured frame
- line_irq_pulse  output  1  end of a captured line
- vsync_irq_pulse  output  1  start of vertical blanking, any state except IDLE
- frame_end_irq_pulse  output  1  end of a captured frame

Behaviour:
- Reset: all outputs 0, state IDLE, frame counter 0, edge-history registers 0.
- Blanking levels: vblank = (vsync == dcmi_vspol); hblank = (hsync == dcmi_hspol).
- History registers vblank_d / hblank_d update every cycle.
- Edges, valid only when enable was also high the previous cycle:
  - sof = vblank_d & ~vblank
  - eof = ~vblank_d & vblank
  - eol = ~hblank_d & hblank
- All outputs are registered. A sync change sampled at edge N is reflected on the outputs after edge N+1 (one-cycle latency). The datapath delays pixels by one cycle to align with line_valid.
- Polarity and FCRC may change only while dcmi_enable = 0; behaviour is undefined otherwise.
- FSM states: IDLE, WAIT_SOF, ACTIVE, SKIP.
  - Any state, dcmi_enable = 0: go to IDLE next cycle; clear line_cnt, frame counter and line_valid; emit no pulses.
  - IDLE: enable & capture -> WAIT_SOF; frame counter := 0. Capture never starts mid-frame.
  - WAIT_SOF, ~capture: go to IDLE.
  - WAIT_SOF, sof: go to ACTIVE if the frame is selected, else SKIP; frame counter increments on every sof (2-bit, wraps 3 -> 0); line_cnt := 0.
  - Frame selection: fcrc 00/11 always; 01 when counter[0] == 0; 10 when counter == 0. The counter value tested is the one before the increment.
  - ACTIVE: line_valid = ~vblank & ~hblank.
  - ACTIVE, eol: line_irq_pulse = 1; line_cnt increments and saturates at all-ones.
  - ACTIVE, eof: frame_end_irq_pulse = 1. Then:
    - snapshot mode: capture_clr = 1, go to IDLE;
    - continuous mode with capture still high: go to WAIT_SOF;
    - continuous mode with capture low: go to IDLE.
  - ACTIVE, capture deasserted mid-frame: the current frame completes, then the FSM goes to IDLE.
  - SKIP: line_valid = 0; no line or frame_end pulses. On eof go to WAIT_SOF, or to IDLE if ~capture.
- vsync_irq_pulse = 1 on eof in WAIT_SOF, ACTIVE or SKIP.
- Simultaneous eol and eof in ACTIVE: line_irq_pulse and frame_end_irq_pulse fire in the same cycle, and line_cnt counts that line.
- sof and eof cannot occur in the same cycle, since both derive from one signal.
- Enable rising while vsync is already active: no sof is generated, so capture waits for the next frame.
- Async reset mid-frame returns to the reset state immediately. The first sof after reset release starts capture.

Decomposition:
- Shared package dcmi_pkg holds:
  - FSM state enum (IDLE = 2'd0, WAIT_SOF = 2'd1, ACTIVE = 2'd2, SKIP = 2'd3);
  - FCRC encodings FCRC_ALL = 2'b00, FCRC_HALF = 2'b01, FCRC_QUARTER = 2'b10.
- One sub-module, dcmi_sync_edge: polarity normalization, history register and enable-qualified rise/fall detection. It is instantiated twice, for vsync and hsync.

Test Plan:
- Continuous, fcrc = 00, vspol = hspol = 1, 3 frames of 4 lines -> 3 frame_end_irq_pulse, 12 line_irq_pulse, 3 vsync_irq_pulse, line_cnt = 4 at each frame end, capture_clr never asserted.
- Snapshot, 2 frames presented -> only frame 1 captured; capture_clr pulses in the same cycle as frame_end_irq_pulse; FSM in IDLE; frame 2 produces no pulses and line_valid stays 0.
- fcrc = 10, 8 frames -> frames 1 and 5 captured (2 frame_end pulses); 6 skipped frames give line_valid = 0; vsync_irq_pulse = 8.
- Enable and capture raised mid-frame (vsync active) -> no line pulses until the next sof; first frame_end only at the end of the following full frame.
- Capture dropped in the middle of line 2 of 4, continuous mode -> frame finishes (line_cnt = 4, one frame_end), then IDLE; the next frame produces no line pulses.
- hsync and vsync enter blanking in the same cycle -> line_irq_pulse and frame_end_irq_pulse both high one cycle later; enable dropped mid-line -> line_valid = 0 and state IDLE on the next cycle.
